// File: rtl/qspi_rom_responder_if.sv
// QSPI pad-side bus between the ROM-fetch initiator and the flash-emulating responder.
interface qspi_rom_responder_if;
  logic       cs_n;
  logic       sclk;
  logic [3:0] dq_in;
  logic [3:0] dq_out;
  logic [3:0] dq_oeb;

  modport master (output cs_n, sclk, dq_in, input dq_out, dq_oeb);
  modport slave  (input cs_n, sclk, dq_in, output dq_out, dq_oeb);
endinterface

// File: rtl/qspi_rom_responder.sv
// SPI/QSPI flash target emulating the program ROM: decodes READ (0x03) and quad fast read
// (0xEB, with continuous-read mode) and serves bytes from a registered byte-wide memory.
module qspi_rom_responder #(
  parameter int unsigned ADDR_W = 7
) (
  input  logic                clk_i,
  input  logic                rst_n,
  qspi_rom_responder_if.slave bus,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_data,
  output logic                active,
  output logic                cont_mode
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned SH_W  = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_QREAD = 8'hEB;

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_S, ADDR_Q, MODE, DUMMY, DATA_S, DATA_Q, IGNORE
  } state_t;

  // Two-flop synchronisers plus one edge-detect stage for cs_n and sclk
  logic [2:0] cs_sync, sclk_sync;
  logic [3:0] dq_s1, dq_s2;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cs_sync   <= 3'b111;
      sclk_sync <= 3'b000;
      dq_s1     <= 4'h0;
      dq_s2     <= 4'h0;
    end else begin
      cs_sync   <= {cs_sync[1:0], bus.cs_n};
      sclk_sync <= {sclk_sync[1:0], bus.sclk};
      dq_s1     <= bus.dq_in;
      dq_s2     <= dq_s1;
    end
  end

  logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
  assign sclk_rise_c =  sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall_c = ~sclk_sync[1] &  sclk_sync[2];
  assign cs_rise_c   =  cs_sync[1]   & ~cs_sync[2];
  assign cs_fall_c   = ~cs_sync[1]   &  cs_sync[2];

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic [7:0]          tx_q, tx_d;
  logic [7:0]          fetch_q, fetch_d;
  logic                rd_q, rd_d;
  logic [3:0]          dq_out_q, dq_out_d;
  logic [3:0]          dq_oeb_q, dq_oeb_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                cont_q, cont_d;
  logic                active_q, active_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      tx_q       <= 8'h00;
      fetch_q    <= 8'h00;
      rd_q       <= 1'b0;
      dq_out_q   <= 4'h0;
      dq_oeb_q   <= 4'hF;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      cont_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      fetch_q    <= fetch_d;
      rd_q       <= rd_d;
      dq_out_q   <= dq_out_d;
      dq_oeb_q   <= dq_oeb_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      cont_q     <= cont_d;
      active_q   <= active_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    tx_d       = tx_q;
    fetch_d    = fetch_q;
    rd_d       = mem_rd_q;
    dq_out_d   = dq_out_q;
    dq_oeb_d   = dq_oeb_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    cont_d     = cont_q;

    // Read data lands one cycle after the strobe; a read that straddles cs_n rising is dropped
    if (rd_q && state_q != IDLE) fetch_d = mem_data;

    if (cs_rise_c) begin
      state_d  = IDLE;
      cnt_d    = '0;
      dq_oeb_d = 4'hF;
      dq_out_d = 4'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall_c) begin
            state_d = cont_q ? ADDR_Q : CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (sclk_rise_c) begin
            sh_d  = SH_W'({sh_q, dq_s2[0]});
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d = '0;
              case (sh_d[7:0])
                CMD_READ:  state_d = ADDR_S;
                CMD_QREAD: state_d = ADDR_Q;
                default:   state_d = IGNORE;
              endcase
            end
          end
        end
        ADDR_S: begin
          if (sclk_rise_c) begin
            sh_d  = SH_W'({sh_q, dq_s2[0]});
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(23)) begin
              state_d    = DATA_S;
              cnt_d      = '0;
              mem_rd_d   = 1'b1;
              mem_addr_d = sh_d[ADDR_W-1:0];
            end
          end
        end
        ADDR_Q: begin
          if (sclk_rise_c) begin
            sh_d  = SH_W'({sh_q, dq_s2});
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(5)) begin
              state_d    = MODE;
              cnt_d      = '0;
              mem_rd_d   = 1'b1;
              mem_addr_d = sh_d[ADDR_W-1:0];
            end
          end
        end
        MODE: begin
          if (sclk_rise_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(0)) cont_d = (dq_s2 == 4'hA);
            if (cnt_q == CNT_W'(1)) begin
              state_d = DUMMY;
              cnt_d   = '0;
            end
          end
        end
        DUMMY: begin
          if (sclk_rise_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(3)) begin
              state_d = DATA_Q;
              cnt_d   = '0;
            end
          end
        end
        DATA_S: begin
          // First bit of each byte comes from the fetch buffer and kicks off the next prefetch
          if (sclk_fall_c) begin
            dq_oeb_d = 4'b1101;
            cnt_d    = (cnt_q == CNT_W'(7)) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(0)) begin
              dq_out_d   = {2'b00, fetch_q[7], 1'b0};
              tx_d       = {fetch_q[6:0], 1'b0};
              mem_rd_d   = 1'b1;
              mem_addr_d = mem_addr_q + ADDR_W'(1);
            end else begin
              dq_out_d = {2'b00, tx_q[7], 1'b0};
              tx_d     = {tx_q[6:0], 1'b0};
            end
          end
        end
        DATA_Q: begin
          if (sclk_fall_c) begin
            dq_oeb_d = 4'b0000;
            if (cnt_q == CNT_W'(0)) begin
              dq_out_d   = fetch_q[7:4];
              tx_d       = {fetch_q[3:0], 4'h0};
              mem_rd_d   = 1'b1;
              mem_addr_d = mem_addr_q + ADDR_W'(1);
              cnt_d      = CNT_W'(1);
            end else begin
              dq_out_d = tx_q[7:4];
              cnt_d    = '0;
            end
          end
        end
        IGNORE: begin
          dq_oeb_d = 4'hF;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    active_d = (state_d != IDLE);
  end

  assign bus.dq_out = dq_out_q;
  assign bus.dq_oeb = dq_oeb_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign cont_mode  = cont_q;
  assign active     = active_q;

endmodule

// File: tb/tb_qspi_rom_responder.sv
// Bench for qspi_rom_responder: acts as the QSPI initiator and a registered ROM, and
// checks bus outputs against a transaction-level model of the flash read protocol.
`timescale 1ns/1ps
module tb_qspi_rom_responder;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned HALF   = 8;   // sclk half period in clk_i cycles
  localparam time         SETTLE = 60;  // outputs must be stable this long after a bus change

  logic clk_i = 1'b0;
  logic rst_n;
  always #5 clk_i = ~clk_i;

  qspi_rom_responder_if bus();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              active, cont_mode;

  qspi_rom_responder #(.ADDR_W(ADDR_W)) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .active    (active),
    .cont_mode (cont_mode)
  );

  // Registered-read ROM plus a log of every read strobe
  logic [7:0]        rom [DEPTH];
  int                rd_cnt = 0;
  logic [ADDR_W-1:0] rd_log [$];
  always @(posedge clk_i) begin
    if (mem_rd) begin
      mem_data <= rom[mem_addr];
      rd_cnt++;
      rd_log.push_back(mem_addr);
    end
  end

  // Model expectations for the bus outputs once they have settled
  logic [3:0] exp_out, exp_oeb;
  logic       exp_active, exp_cont;
  bit         chk_en = 1'b0;
  time        last_change = 0;
  int         n_chk = 0, n_pass = 0;
  logic [7:0] rx [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // Per-cycle compare against the model, skipped while the synchroniser latency is in flight
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_i);
      if (chk_en && ($time - last_change) >= SETTLE) begin
        check("dq_oeb", 32'(bus.dq_oeb), 32'(exp_oeb));
        check("dq_out", 32'(bus.dq_out & ~exp_oeb), 32'(exp_out & ~exp_oeb));
        check("active", 32'(active), 32'(exp_active));
        check("cont_mode", 32'(cont_mode), 32'(exp_cont));
      end
      @(posedge clk_i);
      #1;
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [23:0] a, input int k);
    int idx;
    idx = (int'(a[ADDR_W-1:0]) + k) % DEPTH;
    return rom[idx];
  endfunction

  function automatic logic sbit(input logic [23:0] a, input int j);
    logic [7:0] b;
    b = model_byte(a, j / 8);
    return b[7 - (j % 8)];
  endfunction

  function automatic logic [3:0] qnib(input logic [23:0] a, input int j);
    logic [7:0] b;
    b = model_byte(a, j / 2);
    return (j % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  task automatic cs_low();
    bus.cs_n = 1'b0; exp_active = 1'b1; last_change = $time;
    tick(HALF);
  endtask

  task automatic cs_high();
    bus.cs_n = 1'b1; exp_active = 1'b0; exp_oeb = 4'hF; last_change = $time;
    tick(2 * HALF);
  endtask

  // One sclk period: sample DO, rise, then fall with the model's post-fall outputs
  task automatic pulse(input logic [3:0] d, input logic [3:0] nout, input logic [3:0] noeb,
                       output logic [3:0] smp);
    bus.dq_in = d;
    smp = bus.dq_out;
    bus.sclk = 1'b1; last_change = $time;
    tick(HALF);
    exp_out = nout; exp_oeb = noeb;
    bus.sclk = 1'b0; last_change = $time;
    tick(HALF);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    logic [3:0] smp;
    for (int i = 7; i >= 0; i--) pulse({3'b000, c[i]}, 4'h0, 4'hF, smp);
  endtask

  task automatic single_read(input logic [23:0] addr, input int n);
    logic [3:0] smp;
    cs_low();
    send_cmd(8'h03);
    for (int i = 23; i >= 1; i--) pulse({3'b000, addr[i]}, 4'h0, 4'hF, smp);
    pulse({3'b000, addr[0]}, {2'b00, sbit(addr, 0), 1'b0}, 4'b1101, smp);
    for (int j = 0; j < 8 * n; j++) begin
      pulse(4'h0, {2'b00, sbit(addr, j + 1), 1'b0}, 4'b1101, smp);
      rx[j / 8] = {rx[j / 8][6:0], smp[1]};
    end
  endtask

  task automatic quad_read(input bit has_cmd, input logic [23:0] addr, input logic [7:0] mode,
                           input int n);
    logic [3:0] smp;
    cs_low();
    if (has_cmd) send_cmd(8'hEB);
    for (int k = 5; k >= 0; k--) pulse(addr[4 * k + 3 -: 4], 4'h0, 4'hF, smp);
    exp_cont = (mode[7:4] == 4'hA);
    pulse(mode[7:4], 4'h0, 4'hF, smp);
    pulse(mode[3:0], 4'h0, 4'hF, smp);
    for (int d = 0; d < 3; d++) pulse(4'h0, 4'h0, 4'hF, smp);
    pulse(4'h0, qnib(addr, 0), 4'h0, smp);
    for (int j = 0; j < 2 * n; j++) begin
      pulse(4'h0, qnib(addr, j + 1), 4'h0, smp);
      rx[j / 2] = {rx[j / 2][3:0], smp};
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dq_out"}, 32'(bus.dq_out), 32'h0);
    check({tag, "_dq_oeb"}, 32'(bus.dq_oeb), 32'hF);
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'h0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_active"}, 32'(active), 32'h0);
    check({tag, "_cont"}, 32'(cont_mode), 32'h0);
  endtask

  initial begin
    int         snap;
    logic [3:0] smp;

    rst_n = 1'b0; bus.cs_n = 1'b1; bus.sclk = 1'b0; bus.dq_in = 4'h0;
    exp_out = 4'h0; exp_oeb = 4'hF; exp_active = 1'b0; exp_cont = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = 8'((i * 37 + 11) ^ (i >> 2));
    rom[5] = 8'hA5; rom[6] = 8'h3C; rom[127] = 8'h5A; rom[0] = 8'hC3;
    rom[32] = 8'h96; rom[2] = 8'h4E;

    tick(4);
    check_reset_outputs("por");
    rst_n = 1'b1; last_change = $time; chk_en = 1'b1;
    tick(10);

    // Single-bit READ of two bytes from 0x05
    snap = rd_cnt;
    single_read(24'h000005, 2);
    check("s_byte0", 32'(rx[0]), 32'(model_byte(24'h5, 0)));
    check("s_byte1", 32'(rx[1]), 32'(model_byte(24'h5, 1)));
    check("s_lit0", 32'(rx[0]), 32'hA5);
    check("s_lit1", 32'(rx[1]), 32'h3C);
    check("s_rd_cnt", 32'(rd_cnt - snap), 32'd4);
    check("s_rd_addr0", 32'(rd_log[snap]), 32'h05);
    cs_high();
    check("s_oeb_after", 32'(bus.dq_oeb), 32'hF);

    // Quad read across the top of the aliased memory
    snap = rd_cnt;
    quad_read(1'b1, 24'h00007F, 8'h00, 2);
    check("q_byte0", 32'(rx[0]), 32'(model_byte(24'h7F, 0)));
    check("q_byte1", 32'(rx[1]), 32'(model_byte(24'h7F, 1)));
    check("q_lit0", 32'(rx[0]), 32'h5A);
    check("q_lit1", 32'(rx[1]), 32'hC3);
    check("q_rd_addr0", 32'(rd_log[snap]), 32'h7F);
    check("q_rd_wrap", 32'(rd_log[snap + 1]), 32'h00);
    check("q_cont", 32'(cont_mode), 32'h0);
    cs_high();

    // Continuous-read mode: second transaction starts straight at the address
    quad_read(1'b1, 24'h000010, 8'hA0, 1);
    check("c_byte0", 32'(rx[0]), 32'(model_byte(24'h10, 0)));
    check("c_cont_set", 32'(cont_mode), 32'h1);
    cs_high();
    check("c_cont_kept", 32'(cont_mode), 32'h1);
    snap = rd_cnt;
    quad_read(1'b0, 24'h000020, 8'hA0, 1);
    check("c2_byte0", 32'(rx[0]), 32'(model_byte(24'h20, 0)));
    check("c2_lit0", 32'(rx[0]), 32'h96);
    check("c2_rd_addr0", 32'(rd_log[snap]), 32'h20);

    // Reset mid-DATA_Q with continuous mode latched
    chk_en = 1'b0;
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("mid");
    bus.cs_n = 1'b1;
    tick(4);
    rst_n = 1'b1;
    exp_out = 4'h0; exp_oeb = 4'hF; exp_active = 1'b0; exp_cont = 1'b0;
    last_change = $time; chk_en = 1'b1;
    tick(8);

    // After reset the command byte must be decoded again
    single_read(24'h000006, 1);
    check("r_lit0", 32'(rx[0]), 32'h3C);
    cs_high();

    // Unknown command: stays tri-stated, never reads memory
    snap = rd_cnt;
    cs_low();
    send_cmd(8'h9F);
    for (int i = 0; i < 32; i++) pulse(4'h1, 4'h0, 4'hF, smp);
    check("u_no_rd", 32'(rd_cnt - snap), 32'd0);
    check("u_active", 32'(active), 32'h1);
    check("u_oeb", 32'(bus.dq_oeb), 32'hF);
    cs_high();
    check("u_active_off", 32'(active), 32'h0);

    // Abort after 12 address bits, then a clean read of address 2
    cs_low();
    send_cmd(8'h03);
    for (int i = 0; i < 12; i++) pulse({3'b000, i[0]}, 4'h0, 4'hF, smp);
    cs_high();
    snap = rd_cnt;
    single_read(24'h000002, 1);
    check("a_byte0", 32'(rx[0]), 32'(model_byte(24'h2, 0)));
    check("a_lit0", 32'(rx[0]), 32'h4E);
    check("a_rd_addr0", 32'(rd_log[snap]), 32'h02);
    cs_high();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
